regfile_alu_sequencer: RTL and testbench



---
 rtl/regfile_alu_sequencer.sv | 112 +++++++++++
 tb/tb_regfile_alu_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer: one-button RR -> F -> WB strobe sequencer with step mode and op counter.
// Optional REGFILE_SEQ_DEBOUNCE_EN debounces the synchronized start button for DB_CYCLES cycles.
module regfile_alu_sequencer #(
  parameter int PULSE_W   = 4,
  parameter int GAP_W     = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_btn,
  input  logic             step_mode,
  input  logic             wb_en,
  output logic             clk_RR,
  output logic             clk_F,
  output logic             clk_WB,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {IDLE, S_RR, G_RR, S_F, G_F, S_WB, G_WB} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_prev, r_step, r_wb;
  logic       w_lvl, w_start_evt, w_tick, w_fin, w_gap_end, w_strobe_next;
`ifdef REGFILE_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  logic [DB_W-1:0] r_db_cnt;
  logic            r_db;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync[1] == r_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
      r_db     <= r_sync[1];
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end
  assign w_lvl = r_db;
`else
  assign w_lvl = r_sync[1];
`endif
  assign w_start_evt   = w_lvl & ~r_prev;
  assign w_tick        = r_cnt == 8'd0;
  assign w_strobe_next = (w_next == S_RR) || (w_next == S_F) || (w_next == S_WB);
  always_comb begin
    w_next    = r_state;
    w_fin     = 1'b0;
    w_gap_end = 1'b0;
    case (r_state)
      IDLE: w_next = !w_start_evt ? IDLE : phase == 2'd1 ? S_F : phase == 2'd2 ? S_WB : S_RR;
      S_RR: w_next = w_tick ? G_RR : S_RR;
      G_RR: begin
        w_gap_end = w_tick;
        w_next    = !w_tick ? G_RR : r_step ? IDLE : S_F;
      end
      S_F:  w_next = w_tick ? G_F : S_F;
      G_F: begin
        w_gap_end = w_tick;
        w_fin     = w_tick & ~r_wb;
        w_next    = !w_tick ? G_F : (r_step | ~r_wb) ? IDLE : S_WB;
      end
      S_WB: w_next = w_tick ? G_WB : S_WB;
      G_WB: begin
        w_gap_end = w_tick;
        w_fin     = w_tick;
        w_next    = w_tick ? IDLE : G_WB;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_step   <= 1'b0;
      r_wb     <= 1'b0;
      clk_RR   <= 1'b0;
      clk_F    <= 1'b0;
      clk_WB   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      phase    <= 2'd0;
      op_count <= '0;
    end else begin
      r_sync  <= {r_sync[0], start_btn};
      r_prev  <= w_lvl;
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? (w_strobe_next ? 8'(PULSE_W - 1) : 8'(GAP_W - 1)) :
                 w_tick ? 8'd0 : r_cnt - 8'd1;
      if (r_state == IDLE && w_start_evt) begin
        r_step <= step_mode;
        r_wb   <= wb_en;
      end
      clk_RR <= w_next == S_RR;
      clk_F  <= w_next == S_F;
      clk_WB <= w_next == S_WB;
      busy   <= w_next != IDLE;
      done   <= w_fin;
      if (w_gap_end) phase <= w_fin ? 2'd0 : phase + 2'd1;
      if (w_fin) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// tb_regfile_alu_sequencer: randomized operations checked against a phase-schedule reference model.
module tb_regfile_alu_sequencer;
  localparam int PW = 4;
  localparam int GW = 4;
  localparam int CW = 2;
  localparam int DB = 8;
`ifdef REGFILE_SEQ_DEBOUNCE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 6;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start_btn = 1'b0, step_mode = 1'b0, wb_en = 1'b0;
  logic clk_RR, clk_F, clk_WB, busy, done;
  logic [1:0] phase;
  logic [CW-1:0] op_count;
  int checks = 0, errors = 0;
  int m_phase = 0, m_count = 0, cyc = 0;

  regfile_alu_sequencer #(.PULSE_W(PW), .GAP_W(GW), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .step_mode(step_mode), .wb_en(wb_en),
    .clk_RR(clk_RR), .clk_F(clk_F), .clk_WB(clk_WB), .busy(busy), .done(done),
    .phase(phase), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One busy cycle: compare, then poke the inputs mid-operation (must all be ignored).
  task automatic busy_cycle(input logic [2:0] strb);
    chk("strobes", {29'd0, clk_RR, clk_F, clk_WB}, {29'd0, strb});
    chk("busy", busy, 1);
    chk("done_low", done, 0);
    cyc++;
    if (cyc == 2) begin
      start_btn = 1'b1;
      step_mode = 1'($urandom);
      wb_en     = 1'($urandom);
    end
    if (cyc == 5) start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input bit st, input bit wb);
    bit fin, seen;
    int p;
    repeat (10) begin
      chk("idle_busy", busy, 0);
      @(negedge clk);
    end
    step_mode = st;
    wb_en     = wb;
    start_btn = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < LAT && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("start_seen", seen, 1);
    start_btn = 1'b0;
    if (!seen) return;
    cyc = 0;
    p   = m_phase;
    fin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (PW) busy_cycle(3'b100 >> p);
      repeat (GW) busy_cycle(3'b000);
      fin = (p == 2) || (p == 1 && !wb);
      p   = fin ? 0 : p + 1;
      if (fin || st) break;
    end
    m_phase = p;
    if (fin) m_count = (m_count + 1) % (1 << CW);
    chk("end_busy", busy, 0);
    chk("end_strobes", {29'd0, clk_RR, clk_F, clk_WB}, 0);
    chk("done", done, fin);
    chk("op_count", op_count, m_count);
    chk("phase", phase, m_phase);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  initial begin
    bit st, wb, seen;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {29'd0, clk_RR, clk_F, clk_WB}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", phase, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1'b1;
    run_op(0, 1);
    run_op(0, 0);
    repeat (3) run_op(1, 1);
    repeat (5) run_op(0, 1);
    for (int n = 0; n < 20; n++) begin
      st = 1'($urandom);
      wb = 1'($urandom);
      if (m_phase == 2) wb = 1'b1;
      run_op(st, wb);
    end
    for (int n = 0; n < 2 && m_phase != 0; n++) run_op(1, 1);
    chk("phase_zero", phase, 0);
    repeat (10) @(negedge clk);
    step_mode = 1'b0;
    wb_en     = 1'b1;
    start_btn = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < LAT + 2 * (PW + GW) && !seen; i++) begin
      @(negedge clk);
      seen = clk_F;
    end
    chk("reach_F", seen, 1);
    rst_n     = 1'b0;
    start_btn = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {29'd0, clk_RR, clk_F, clk_WB}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_count", op_count, 0);
    rst_n   = 1'b1;
    m_phase = 0;
    m_count = 0;
    repeat (15) begin
      @(negedge clk);
      chk("post_rst_idle", {28'd0, busy, clk_RR, clk_F, clk_WB}, 0);
    end
`ifdef REGFILE_SEQ_DEBOUNCE_EN
    repeat (3) begin
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) begin
      chk("glitch_idle", {28'd0, busy, clk_RR, clk_F, clk_WB}, 0);
      @(negedge clk);
    end
`endif
    run_op(0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
